// File: rtl/decoder_2x4_seq.sv
// 2-to-4 one-hot decoder with valid/ready handshakes and a 2-entry output FIFO.
// Define DEC_ACCUM_EN to OR beats of a frame together and emit one word per frame.
module decoder_2x4_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_code,
    input  logic       in_en,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_onehot,
    output logic [7:0] out_cnt
);

    logic [1:0] occ_q, occ_d;
    logic [3:0] head_q, head_d;
    logic [3:0] tail_q, tail_d;
    logic [7:0] cnt_q, cnt_d;
    logic       rdy_q, rdy_d;

    logic [3:0] dec_word;
    logic [3:0] push_word;
    logic       accept;
    logic       pop;
    logic       push;

    always_comb begin
        dec_word = 4'b0000;
        if (in_en) begin
            dec_word = 4'b0001 << in_code;
        end
    end

    assign accept = in_valid & rdy_q;
    assign pop    = (occ_q != 2'd0) & out_ready;

`ifdef DEC_ACCUM_EN
    typedef enum logic {
        IDLE,
        ACC
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] acc_q, acc_d;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        push      = 1'b0;
        push_word = acc_q | dec_word;
        if (accept) begin
            if (in_last) begin
                push    = 1'b1;
                acc_d   = 4'b0000;
                state_d = IDLE;
            end else begin
                acc_d   = acc_q | dec_word;
                state_d = ACC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end
`else
    logic unused_in_last;

    assign unused_in_last = in_last;

    always_comb begin
        push      = accept;
        push_word = dec_word;
    end
`endif

    // Occupancy 2 never coincides with a push, since in_ready is low there.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({push, pop})
            2'b11: begin
                head_d = push_word;
            end
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = push_word;
                    occ_d  = 2'd1;
                end else begin
                    tail_d = push_word;
                    occ_d  = 2'd2;
                end
            end
            2'b01: begin
                if (occ_q == 2'd2) begin
                    head_d = tail_q;
                    occ_d  = 2'd1;
                end else begin
                    head_d = 4'b0000;
                    occ_d  = 2'd0;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (pop) begin
            cnt_d = cnt_q + 8'd1;
        end
        rdy_d = (occ_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= 2'd0;
            head_q <= 4'b0000;
            tail_q <= 4'b0000;
            cnt_q  <= 8'd0;
            rdy_q  <= 1'b0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            rdy_q  <= rdy_d;
        end
    end

    assign in_ready   = rdy_q;
    assign out_valid  = (occ_q != 2'd0);
    assign out_onehot = head_q;
    assign out_cnt    = cnt_q;

endmodule

// File: tb/tb_decoder_2x4_seq.sv
// Directed testbench for decoder_2x4_seq; checks use immediate assertions.
// Frame-accumulate vectors run when DEC_ACCUM_EN is defined.
module tb_decoder_2x4_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_code;
    logic       in_en;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_onehot;
    logic [7:0] out_cnt;

    int n_tests;
    int n_fail;

    decoder_2x4_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_en      (in_en),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_cnt    (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = 2'd0;
        in_en     = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        #2;
        chk("rst_valid", 8'(out_valid), 8'd0);
        chk("rst_ready", 8'(in_ready), 8'd0);
        chk("rst_onehot", 8'(out_onehot), 8'd0);
        chk("rst_cnt", out_cnt, 8'd0);

        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 8'(in_ready), 8'd1);

`ifndef DEC_ACCUM_EN
        // Streaming codes 0..3
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_en     = 1'b1;
        in_code   = 2'd0;
        step();
        chk("s0_valid", 8'(out_valid), 8'd1);
        chk("s0_onehot", 8'(out_onehot), 8'h01);
        in_code = 2'd1;
        step();
        chk("s1_onehot", 8'(out_onehot), 8'h02);
        chk("s1_cnt", out_cnt, 8'd1);
        in_code = 2'd2;
        step();
        chk("s2_onehot", 8'(out_onehot), 8'h04);
        in_code = 2'd3;
        step();
        chk("s3_onehot", 8'(out_onehot), 8'h08);
        chk("s3_ready", 8'(in_ready), 8'd1);
        in_valid = 1'b0;
        step();
        chk("s_cnt4", out_cnt, 8'd4);
        chk("s_empty", 8'(out_valid), 8'd0);

        // in_en=0 yields an all-zero word that is still valid
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_en     = 1'b0;
        in_code   = 2'd3;
        step();
        chk("en0_valid", 8'(out_valid), 8'd1);
        chk("en0_onehot", 8'(out_onehot), 8'h00);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("en0_cnt", out_cnt, 8'd5);

        // Backpressure with three words offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_en     = 1'b1;
        in_code   = 2'd1;
        step();
        chk("bp_a_ready", 8'(in_ready), 8'd1);
        in_code = 2'd2;
        step();
        chk("bp_full_ready", 8'(in_ready), 8'd0);
        chk("bp_head_a", 8'(out_onehot), 8'h02);
        in_code = 2'd3;
        step();
        step();
        chk("bp_hold_head", 8'(out_onehot), 8'h02);
        chk("bp_hold_ready", 8'(in_ready), 8'd0);
        chk("bp_hold_cnt", out_cnt, 8'd5);
        out_ready = 1'b1;
        step();
        chk("bp_head_b", 8'(out_onehot), 8'h04);
        chk("bp_ready_up", 8'(in_ready), 8'd1);
        chk("bp_cnt6", out_cnt, 8'd6);
        step();
        chk("bp_head_c", 8'(out_onehot), 8'h08);
        chk("bp_cnt7", out_cnt, 8'd7);
        in_valid = 1'b0;
        step();
        chk("bp_cnt8", out_cnt, 8'd8);
        chk("bp_empty", 8'(out_valid), 8'd0);

        // Counter wrap: 248 more pops reach 256 total
        in_valid = 1'b1;
        in_code  = 2'd0;
        repeat (249) step();
        chk("wrap_cnt0", out_cnt, 8'd0);
        step();
        chk("wrap_cnt1", out_cnt, 8'd1);
        in_valid = 1'b0;
        step();
        chk("wrap_cnt2", out_cnt, 8'd2);

        // Asynchronous reset with two words stored
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 2'd0;
        step();
        in_code = 2'd1;
        step();
        chk("pre_rst_valid", 8'(out_valid), 8'd1);
        chk("pre_rst_ready", 8'(in_ready), 8'd0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 8'(out_valid), 8'd0);
        chk("arst_onehot", 8'(out_onehot), 8'h00);
        chk("arst_cnt", out_cnt, 8'd0);
        chk("arst_ready", 8'(in_ready), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 8'(in_ready), 8'd1);
        chk("post_rst_valid", 8'(out_valid), 8'd0);
        out_ready = 1'b1;
        step();
        chk("post_rst_cnt", out_cnt, 8'd0);
`else
        // Frame accumulate: (1,0) (3,0) (en0,1) then (0,1)
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_en     = 1'b1;
        in_code   = 2'd1;
        in_last   = 1'b0;
        step();
        chk("acc_b1_valid", 8'(out_valid), 8'd0);
        chk("acc_b1_ready", 8'(in_ready), 8'd1);
        in_code = 2'd3;
        step();
        chk("acc_b2_valid", 8'(out_valid), 8'd0);
        in_en   = 1'b0;
        in_last = 1'b1;
        step();
        chk("acc_f1_valid", 8'(out_valid), 8'd1);
        chk("acc_f1_word", 8'(out_onehot), 8'h0a);
        in_en   = 1'b1;
        in_code = 2'd0;
        step();
        chk("acc_f2_word", 8'(out_onehot), 8'h01);
        chk("acc_f2_cnt", out_cnt, 8'd1);
        in_valid = 1'b0;
        step();
        chk("acc_cnt2", out_cnt, 8'd2);
        chk("acc_empty", 8'(out_valid), 8'd0);

        // Reset discards a partially accumulated frame
        in_valid = 1'b1;
        in_code  = 2'd2;
        in_last  = 1'b0;
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("acc_arst_cnt", out_cnt, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        in_valid = 1'b1;
        in_code  = 2'd0;
        in_last  = 1'b1;
        step();
        chk("acc_post_rst_word", 8'(out_onehot), 8'h01);
        in_valid = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
